pwm_deadtime: RTL and testbench

- Downstream consumer of the triangle carrier generator.
- Compares the carrier (triangle_wave mod_out) against a duty value latched once per carrier period, giving centre-aligned PWM.
- Drives a complementary high/low output pair with programmable dead time, suitable for a half-bridge gate stage.
- Guarantees both outputs are never high together.

---
 rtl/pwm_deadtime.sv | 142 ++++++++++++++
 tb/tb_pwm_deadtime.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pwm_deadtime.sv
// Centre-aligned PWM with a complementary high/low output pair and
// programmable dead time, driven from a triangle carrier.
//
// Ports:
//   clk          system clock, all logic on the rising edge
//   rst          synchronous reset, active high
//   enable       1 = run, 0 = force both outputs low
//   carrier_in   triangle carrier, unsigned WIDTH bits
//   duty_in      requested compare value, latched at each carrier valley
//   deadtime_in  dead-time length in clk cycles, sampled on entry to a dead state
//   pwm_hi_out   high-side drive, registered
//   pwm_lo_out   low-side drive, registered
//   update_out   one-cycle pulse the cycle after the duty shadow loads
module pwm_deadtime #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned DT_WIDTH = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [WIDTH-1:0]    carrier_in,
    input  logic [WIDTH-1:0]    duty_in,
    input  logic [DT_WIDTH-1:0] deadtime_in,
    output logic                pwm_hi_out,
    output logic                pwm_lo_out,
    output logic                update_out
);

    typedef enum logic [2:0] {
        OFF,
        DEAD_TO_HI,
        DEAD_TO_LO,
        HI_ON,
        LO_ON
    } state_t;

    state_t              state_q, state_d;
    logic [DT_WIDTH-1:0] dt_cnt_q, dt_cnt_d;
    logic [WIDTH-1:0]    carrier_q;
    logic [WIDTH-1:0]    duty_q;
    logic                slope_q;
    logic                update_q;
    logic                hi_q, lo_q;

    logic rising, falling, valley, raw, enter;

    assign rising  = (carrier_in > carrier_q);
    assign falling = (carrier_in < carrier_q);
    // A valley is the first upward step after the carrier was heading down.
    assign valley  = rising && !slope_q;
    assign raw     = (carrier_q < duty_q);

    // Carrier tracking and duty shadow register.
    always_ff @(posedge clk) begin
        if (rst) begin
            carrier_q <= '0;
            slope_q   <= 1'b0;
            duty_q    <= '0;
            update_q  <= 1'b0;
        end else begin
            carrier_q <= carrier_in;
            if (rising) begin
                slope_q <= 1'b1;
            end else if (falling) begin
                slope_q <= 1'b0;
            end
            if (valley) begin
                duty_q <= duty_in;
            end
            update_q <= valley;
        end
    end

    // Every dead-state entry (from OFF, from an ON state, or on a reversal
    // inside a dead state) heads toward the side raw currently selects, so
    // one shared 'enter' path covers all of them.
    always_comb begin
        state_d  = state_q;
        dt_cnt_d = dt_cnt_q;
        enter    = 1'b0;
        if (!enable) begin
            state_d  = OFF;
            dt_cnt_d = '0;
        end else begin
            case (state_q)
                OFF:   enter = 1'b1;
                HI_ON: enter = !raw;
                LO_ON: enter = raw;
                DEAD_TO_HI: begin
                    if (!raw) begin
                        enter = 1'b1;
                    end else if (dt_cnt_q != '0) begin
                        dt_cnt_d = dt_cnt_q - 1'b1;
                    end else begin
                        state_d = HI_ON;
                    end
                end
                DEAD_TO_LO: begin
                    if (raw) begin
                        enter = 1'b1;
                    end else if (dt_cnt_q != '0) begin
                        dt_cnt_d = dt_cnt_q - 1'b1;
                    end else begin
                        state_d = LO_ON;
                    end
                end
                default: state_d = OFF;
            endcase
            if (enter) begin
                if (deadtime_in == '0) begin
                    state_d = raw ? HI_ON : LO_ON;
                end else begin
                    state_d  = raw ? DEAD_TO_HI : DEAD_TO_LO;
                    dt_cnt_d = deadtime_in - 1'b1;
                end
            end
        end
    end

    // Outputs are registered decodes of the next state so they change on
    // the same edge as the state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OFF;
            dt_cnt_q <= '0;
            hi_q     <= 1'b0;
            lo_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            dt_cnt_q <= dt_cnt_d;
            hi_q     <= (state_d == HI_ON);
            lo_q     <= (state_d == LO_ON);
        end
    end

    assign pwm_hi_out = hi_q;
    assign pwm_lo_out = lo_q;
    assign update_out = update_q;

    no_shoot_through: assert property (@(posedge clk) !(pwm_hi_out && pwm_lo_out));

endmodule

// File: tb/tb_pwm_deadtime.sv
module tb_pwm_deadtime;

    localparam int W  = 8;
    localparam int DW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [W-1:0]  carrier_in = '0;
    logic [W-1:0]  duty_in = '0;
    logic [DW-1:0] deadtime_in = '0;
    logic          hi, lo, upd;

    pwm_deadtime #(.WIDTH(W), .DT_WIDTH(DW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .carrier_in  (carrier_in),
        .duty_in     (duty_in),
        .deadtime_in (deadtime_in),
        .pwm_hi_out  (hi),
        .pwm_lo_out  (lo),
        .update_out  (upd)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    // Reference model: tracks the committed output side and how many
    // both-low cycles remain before that side may turn on.
    int           m_car = 0, m_duty = 0;
    bit           m_slope = 0;
    bit           m_hi = 0, m_lo = 0, m_upd = 0;
    int           m_side = 0;   // 0 none, 1 high, 2 low
    int           m_gap = 0;

    always @(posedge clk) begin : model
        int want;
        bit valley;
        if (rst) begin
            m_car = 0; m_duty = 0; m_slope = 0;
            m_side = 0; m_gap = 0; m_upd = 0;
        end else begin
            want   = (m_car < m_duty) ? 1 : 2;
            valley = (int'(carrier_in) > m_car) && !m_slope;
            m_upd  = valley;
            if (valley) m_duty = int'(duty_in);
            if (int'(carrier_in) > m_car) m_slope = 1;
            else if (int'(carrier_in) < m_car) m_slope = 0;
            m_car = int'(carrier_in);
            if (!enable) begin
                m_side = 0;
                m_gap  = 0;
            end else if (m_side != want) begin
                m_side = want;
                m_gap  = int'(deadtime_in);
            end else if (m_gap > 0) begin
                m_gap--;
            end
        end
        m_hi = (m_side == 1) && (m_gap == 0);
        m_lo = (m_side == 2) && (m_gap == 0);
    end

    // Per-cycle comparison plus a monitor of both-low run lengths.
    int low_run = 0, prev_side = 0, last_gap = 0, events = 0, upd_cnt = 0;

    always @(negedge clk) begin : compare
        int side;
        check("hi", hi, m_hi);
        check("lo", lo, m_lo);
        check("update", upd, m_upd);
        check("no_overlap", hi & lo, 0);
        side = hi ? 1 : (lo ? 2 : 0);
        if (upd) upd_cnt++;
        if (side != 0) begin
            if (low_run > 0 || side != prev_side) begin
                last_gap = low_run;
                events++;
            end
            low_run   = 0;
            prev_side = side;
        end else begin
            low_run++;
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // One triangle period 0..9..1; optionally change duty_in on the rising
    // slope when the carrier reaches chg_at.
    task automatic tri_period(input int chg_at, input logic [W-1:0] new_duty);
        for (int c = 0; c <= 9; c++) begin
            carrier_in = W'(c);
            if (c == chg_at) duty_in = new_duty;
            tick();
        end
        for (int c = 8; c >= 1; c--) begin
            carrier_in = W'(c);
            tick();
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        carrier_in = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int ev0, c0, n;

        // Reset state
        tick();
        check("reset_hi", hi, 0);
        check("reset_lo", lo, 0);
        check("reset_upd", upd, 0);

        // 1. Steady PWM, dead time 3
        enable = 1'b1; duty_in = 8'd5; deadtime_in = 4'd3;
        do_reset();
        tri_period(-1, '0);
        ev0 = events;
        tri_period(-1, '0);
        tri_period(-1, '0);
        check("t1_handovers", events - ev0, 4);
        check("t1_gap", last_gap, 3);

        // 2. Zero dead time
        deadtime_in = 4'd0;
        tri_period(-1, '0);
        ev0 = events;
        tri_period(-1, '0);
        check("t2_handovers", events - ev0, 2);
        check("t2_gap", last_gap, 0);

        // 3. Shadow update: 3 -> 7 mid rising slope
        deadtime_in = 4'd2; duty_in = 8'd3;
        tri_period(-1, '0);
        tri_period(4, 8'd7);
        c0 = upd_cnt;
        tri_period(-1, '0);
        check("t3_update_pulses", upd_cnt - c0, 1);

        // 4. Extremes
        deadtime_in = 4'd3; duty_in = 8'd0;
        do_reset();
        tri_period(-1, '0);
        tri_period(-1, '0);
        ev0 = events;
        tri_period(-1, '0);
        check("t4_zero_toggles", events - ev0, 0);
        check("t4_zero_lo", lo, 1);
        check("t4_zero_hi", hi, 0);

        duty_in = 8'd255;
        do_reset();
        tri_period(-1, '0);
        ev0 = events;
        tri_period(-1, '0);
        tri_period(-1, '0);
        check("t4_full_toggles", events - ev0, 0);
        check("t4_full_hi", hi, 1);
        check("t4_full_lo", lo, 0);

        // 5. Enable drop inside DEAD_TO_HI, then re-enable
        enable = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        tick();
        enable = 1'b0;
        tick();
        check("t5_off_hi", hi, 0);
        check("t5_off_lo", lo, 0);
        enable = 1'b1;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hi) break;
            n++;
        end
        check("t5_reenable_gap", n, 3);

        // Reset while in HI_ON; duty shadow must clear so low side follows
        rst = 1'b1;
        carrier_in = '0;
        tick();
        rst = 1'b0;
        check("t5_rst_hi", hi, 0);
        check("t5_rst_lo", lo, 0);
        check("t5_rst_upd", upd, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (lo || hi) break;
            n++;
        end
        check("t5_rst_gap", n, 3);
        check("t5_rst_side_lo", lo, 1);

        // 6. Reversal two cycles into DEAD_TO_LO, dead time 4
        deadtime_in = 4'd4; duty_in = 8'd5;
        do_reset();
        carrier_in = 8'd0;
        tick();
        carrier_in = 8'd1;
        for (int i = 0; i < 14; i++) tick();
        check("t6_start_hi", hi, 1);
        carrier_in = 8'd6;
        tick();
        tick();
        carrier_in = 8'd2;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (hi) break;
            n++;
        end
        check("t6_low_cycles", n, 5);
        check("t6_gap", last_gap, 6);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
